// File: rtl/flash_reader.sv
// SPI mode-0 boot-flash reader: issues READ (0x03) plus a 24-bit address, then streams
// the requested number of bytes out with a one-cycle valid strobe per byte.
module flash_reader #(
   parameter int ClockDivider  = 0,
   parameter int CountBitWidth = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [23:0]              address,
   input  logic [CountBitWidth-1:0] byte_count,
   output logic                     busy,
   output logic [7:0]               data_out,
   output logic                     data_out_valid,
   output logic                     done,
   output logic                     flash_clk,
   input  logic                     flash_miso,
   output logic                     flash_mosi,
   output logic                     flash_cs_n
);

   localparam int TickW = (ClockDivider < 1) ? 1 : $clog2(ClockDivider + 1);
   localparam logic [TickW-1:0]         TickMax   = TickW'(ClockDivider);
   localparam logic [TickW-1:0]         TickZero  = TickW'(1'b0);
   localparam logic [TickW-1:0]         TickOne   = TickW'(1'b1);
   localparam logic [CountBitWidth-1:0] CountZero = CountBitWidth'(1'b0);
   localparam logic [CountBitWidth-1:0] CountOne  = CountBitWidth'(1'b1);
   localparam logic [7:0]               ReadCmd   = 8'h03;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      CMD      = 3'd2,
      RECV     = 3'd3,
      DESELECT = 3'd4
   } state_t;

   state_t                   state_r, state_s;
   logic [TickW-1:0]         tick_r, tick_s, tick_inc_s;
   logic                     tick_end_s;
   logic                     accept_s;
   logic                     sclk_r, sclk_s;
   logic                     cs_n_r, cs_n_s;
   logic                     mosi_r, mosi_s;
   logic [31:0]              shift_r, shift_s;
   logic [4:0]               bit_cnt_r, bit_cnt_s;
   logic [7:0]               rx_r, rx_s;
   logic [CountBitWidth-1:0] remaining_r, remaining_s;
   logic [7:0]               data_r, data_s;
   logic                     valid_r, valid_s;
   logic                     done_r, done_s;
   logic                     busy_r, busy_s;

   // Next-state and next-output computation for the whole transfer sequencer.
   always_comb begin
      state_s     = state_r;
      sclk_s      = sclk_r;
      cs_n_s      = cs_n_r;
      mosi_s      = mosi_r;
      shift_s     = shift_r;
      bit_cnt_s   = bit_cnt_r;
      rx_s        = rx_r;
      remaining_s = remaining_r;
      data_s      = data_r;
      valid_s     = 1'b0;
      done_s      = 1'b0;
      accept_s    = 1'b0;
      tick_end_s  = (tick_r == TickMax);
      tick_inc_s  = tick_end_s ? TickZero : (tick_r + TickOne);
      tick_s      = tick_inc_s;

      case (state_r)
         IDLE: begin
            tick_s   = TickZero;
            accept_s = start;
         end
         SELECT: begin
            if (tick_end_s) begin
               state_s = CMD;
            end else begin
               state_s = SELECT;
            end
         end
         CMD: begin
            if (tick_end_s) begin
               sclk_s = ~sclk_r;
               // Falling edge: present the next command/address bit.
               if (sclk_r) begin
                  shift_s = {shift_r[30:0], 1'b0};
                  if (bit_cnt_r == 5'd31) begin
                     state_s   = RECV;
                     bit_cnt_s = 5'd0;
                     mosi_s    = 1'b0;
                  end else begin
                     bit_cnt_s = bit_cnt_r + 5'd1;
                     mosi_s    = shift_r[30];
                  end
               end else begin
                  shift_s = shift_r;
               end
            end else begin
               sclk_s = sclk_r;
            end
         end
         RECV: begin
            if (tick_end_s) begin
               sclk_s = ~sclk_r;
               if (!sclk_r) begin
                  rx_s = {rx_r[6:0], flash_miso};
               end else if (bit_cnt_r == 5'd7) begin
                  bit_cnt_s   = 5'd0;
                  data_s      = rx_r;
                  valid_s     = 1'b1;
                  remaining_s = remaining_r - CountOne;
                  if (remaining_r == CountOne) begin
                     state_s = DESELECT;
                     cs_n_s  = 1'b1;
                  end else begin
                     state_s = RECV;
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r + 5'd1;
               end
            end else begin
               rx_s = rx_r;
            end
         end
         DESELECT: begin
            // The last CS-high cycle doubles as the done cycle, so a new start is taken here.
            if (tick_end_s) begin
               state_s  = IDLE;
               accept_s = start;
            end else begin
               state_s = DESELECT;
            end
         end
         default: begin
            state_s = IDLE;
            tick_s  = TickZero;
            cs_n_s  = 1'b1;
            sclk_s  = 1'b0;
            mosi_s  = 1'b0;
         end
      endcase

      if (accept_s) begin
         if (byte_count != CountZero) begin
            state_s     = SELECT;
            tick_s      = TickZero;
            cs_n_s      = 1'b0;
            sclk_s      = 1'b0;
            shift_s     = {ReadCmd, address};
            mosi_s      = ReadCmd[7];
            bit_cnt_s   = 5'd0;
            remaining_s = byte_count;
         end else begin
            done_s = 1'b1;
         end
      end else begin
         done_s = (state_s == DESELECT) && (tick_s == TickMax);
      end

      busy_s = (state_s != IDLE) && !((state_s == DESELECT) && (tick_s == TickMax));
   end

   // State and output registers; all SPI pins come straight from these flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         tick_r      <= TickZero;
         sclk_r      <= 1'b0;
         cs_n_r      <= 1'b1;
         mosi_r      <= 1'b0;
         shift_r     <= 32'h0000_0000;
         bit_cnt_r   <= 5'd0;
         rx_r        <= 8'h00;
         remaining_r <= CountZero;
         data_r      <= 8'h00;
         valid_r     <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         tick_r      <= tick_s;
         sclk_r      <= sclk_s;
         cs_n_r      <= cs_n_s;
         mosi_r      <= mosi_s;
         shift_r     <= shift_s;
         bit_cnt_r   <= bit_cnt_s;
         rx_r        <= rx_s;
         remaining_r <= remaining_s;
         data_r      <= data_s;
         valid_r     <= valid_s;
         done_r      <= done_s;
         busy_r      <= busy_s;
      end
   end

   assign busy           = busy_r;
   assign data_out       = data_r;
   assign data_out_valid = valid_r;
   assign done           = done_r;
   assign flash_clk      = sclk_r;
   assign flash_mosi     = mosi_r;
   assign flash_cs_n     = cs_n_r;

endmodule

// File: doc/flash_reader.md
Name: flash_reader

Overview:
- SPI mode-0 master that reads a contiguous byte range from the serial boot flash using READ (0x03) + 24-bit address.
- Streams the received bytes out one at a time with a valid strobe.
- Sits between the core's boot-copy logic and the `flash` SPI model or pins; its SPI signals are the other end of the `flash` responder.
- Replaces hand-coded bit-banging in the core's startup path.

Parameters:
- ClockDivider, 0, SPI half-period is ClockDivider+1 clk cycles (0 gives flash_clk = clk/2).
- CountBitWidth, 16, width of the byte_count input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- address  input  24  first flash byte address, latched on start.
- byte_count  input  CountBitWidth  number of bytes to read, latched on start.
- busy  output  1  high from the cycle after an accepted start until done.
- data_out  output  8  received byte, MSB first on the wire.
- data_out_valid  output  1  one-cycle strobe; data_out is stable for that cycle.
- done  output  1  one-cycle pulse at the end of the transfer.
- flash_clk  output  1  SPI clock, idle low.
- flash_miso  input  1  SPI data from flash.
- flash_mosi  output  1  SPI data to flash.
- flash_cs_n  output  1  SPI chip select, active low.

Behaviour:
- Reset, asynchronous: flash_cs_n=1, flash_clk=0, flash_mosi=0, busy=0, data_out=0, data_out_valid=0, done=0, FSM=IDLE. Reset mid-transfer aborts immediately; no partial byte is emitted.
- FSM states: IDLE, SELECT, CMD, RECV, DESELECT.
- IDLE, start=1, byte_count!=0:
  - latch address and count.
  - load shift register {8'h03, address}.
  - busy=1 and flash_cs_n=0 next cycle, entering SELECT.
- IDLE, start=1, byte_count=0: done=1 for one cycle next cycle. busy stays 0 and CS is never asserted.
- SELECT: hold for ClockDivider+1 cycles with flash_clk=0 and flash_mosi = MSB of the shift register, then go to CMD.
- Bit timing: a tick counter counts 0..ClockDivider.
  - At each terminal count, flash_clk toggles.
  - On the 0→1 toggle, the clk edge samples flash_miso (RECV only).
  - On the 1→0 toggle, mosi shifts to the next bit.
- CMD: 32 bits, MSB first.
  - After the 32nd falling edge, go to RECV.
  - flash_mosi is 0 during RECV.
- RECV:
  - Each rising edge shifts flash_miso into an 8-bit receive register, MSB first.
  - On the falling edge completing bit 8: data_out is loaded and data_out_valid=1 for exactly one clk, and the remaining count is decremented.
  - Bytes arrive back-to-back with no gaps; CS stays low across bytes and the flash auto-increments the address.
  - When the remaining count reaches 0, go to DESELECT instead of continuing.
- DESELECT:
  - flash_cs_n=1 and flash_clk=0 on entry.
  - Hold ClockDivider+1 cycles (CS-high time), then done=1 for one cycle, busy=0, go to IDLE.
  - start is accepted again on the cycle done is high (busy=0).
- start while busy=1: ignored, with no effect on latched values.
- Latency with ClockDivider=D and N bytes:
  - SELECT (D+1) + CMD 32·2(D+1) + RECV N·8·2(D+1) + DESELECT (D+1) cycles from start acceptance to done.
  - Example: D=0, N=1 gives 1+64+16+1 = 82 cycles.
- Address wraparound beyond 24 bits is the flash's concern. The block never re-issues the command.
- Counter widths: the remaining count uses CountBitWidth bits. byte_count = all ones is legal, i.e. 65535 bytes at default width.
- flash_clk, flash_mosi, flash_cs_n are driven directly from flops (glitch-free).

Test Plan:
- Flash model preloaded with byte[i]=i[7:0]. start with address=0x000000, byte_count=4, D=0 → MOSI shows 0x03,0x00,0x00,0x00; data_out_valid strobes 4 times with 0x00,0x01,0x02,0x03, 16 clk apart; done 82+48=130 cycles after start; CS low throughout, high after.
- address=0x0000FE, byte_count=3 → bytes 0xFE,0xFF,0x00 (wraps the low byte of the pattern, address 0x100); exactly 3 strobes.
- byte_count=0 → done one cycle after start; flash_cs_n never low; no strobes; busy stays 0.
- D=3, byte_count=1, address=0x000010 → flash_clk period 8 clk; data_out=0x10; done 4+256+64+4=328 cycles after start.
- Second start pulsed mid-transfer with different address/count → ignored; the first transfer completes unchanged; a start on the done cycle begins a new transfer correctly.
- rst_n low during RECV of byte 2 of 4 → same cycle: flash_cs_n=1, flash_clk=0, busy=0, no further strobes; after release a fresh 2-byte read returns correct data.
